axi4_sram_slave: RTL and testbench

Parametrised AXI4 memory slave for the PLIC test environment. It accepts independent read and write bursts with IDs and all three burst types, and serves them from an internal byte-strobed word array. It adds configurable read latency, correct WRAP arithmetic, an accurate `rlast`, error responses and optional address-range checking. It sits behind the test interconnect as the default system-memory endpoint.

---
 rtl/axi4_sram_slave.sv | 242 ++++++++++++++++++++++++
 tb/tb_axi4_sram_slave.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_sram_slave.sv
// AXI4 memory slave: independent read/write burst engines over a byte-strobed word array.
// Optional macro AXI4_RANGE_CHECK_EN returns DECERR for beats outside the mapped window.
module axi4_sram_slave #(
  parameter int                   ADDR_BITS    = 32,
  parameter int                   DATA_BITS    = 32,
  parameter int                   ID_BITS      = 4,
  parameter int                   DEPTH        = 1024,
  parameter logic [ADDR_BITS-1:0] BASE_ADDR    = 32'h1000_0000,
  parameter int                   READ_LATENCY = 1
) (
  input  logic                   PCLK,
  input  logic                   PRESETn,
  input  logic [ID_BITS-1:0]     arid_i,
  input  logic [ADDR_BITS-1:0]   araddr_i,
  input  logic [7:0]             arlen_i,
  input  logic [2:0]             arsize_i,
  input  logic [1:0]             arburst_i,
  input  logic                   arvalid_i,
  output logic                   arready_o,
  output logic [ID_BITS-1:0]     rid_o,
  output logic [DATA_BITS-1:0]   rdata_o,
  output logic [1:0]             rresp_o,
  output logic                   rlast_o,
  output logic                   rvalid_o,
  input  logic                   rready_i,
  input  logic [ID_BITS-1:0]     awid_i,
  input  logic [ADDR_BITS-1:0]   awaddr_i,
  input  logic [7:0]             awlen_i,
  input  logic [2:0]             awsize_i,
  input  logic [1:0]             awburst_i,
  input  logic                   awvalid_i,
  output logic                   awready_o,
  input  logic [DATA_BITS-1:0]   wdata_i,
  input  logic [DATA_BITS/8-1:0] wstrb_i,
  input  logic                   wlast_i,
  input  logic                   wvalid_i,
  output logic                   wready_o,
  output logic [ID_BITS-1:0]     bid_o,
  output logic [1:0]             bresp_o,
  output logic                   bvalid_o,
  input  logic                   bready_i
);
  localparam int         STRB_W   = DATA_BITS / 8;
  localparam int         LSB      = $clog2(STRB_W);
  localparam int         IDX_W    = $clog2(DEPTH);
  localparam logic [2:0] SIZE_MAX = 3'(LSB);

  typedef enum logic [1:0] {R_IDLE, R_LAT, R_DATA} r_state_e;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;

  function automatic logic [ADDR_BITS-1:0] next_addr(input logic [ADDR_BITS-1:0] a,
      input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst);
    logic [ADDR_BITS-1:0] step;
    logic [ADDR_BITS-1:0] mask;
    step = ADDR_BITS'(1) << size;
    mask = ((ADDR_BITS'(len) + ADDR_BITS'(1)) << size) - ADDR_BITS'(1);
    case (burst)
      2'b00:   return a;
      2'b10:   return (a & ~mask) | ((a + step) & mask);
      default: return a + step;  // reserved 2'b11 walks like INCR
    endcase
  endfunction

  function automatic logic prot_err(input logic [7:0] len, input logic [2:0] size,
      input logic [1:0] burst);
    logic bad_wrap;
    bad_wrap = (burst == 2'b10) &&
               !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15);
    return (burst == 2'b11) || bad_wrap || (size > SIZE_MAX);
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_BITS-1:0] a);
    return IDX_W'((a - BASE_ADDR) >> LSB);
  endfunction

  function automatic logic [1:0] worst(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

  logic [DATA_BITS-1:0] mem [DEPTH];

  r_state_e             r_state_q, r_state_d;
  logic [ID_BITS-1:0]   rid_q;
  logic [ADDR_BITS-1:0] r_addr_q, r_next, r_load_addr;
  logic [7:0]           r_len_q, r_cnt_q;
  logic [2:0]           r_size_q;
  logic [1:0]           r_burst_q, rresp_q, r_resp_d;
  logic                 r_prot_q, r_oor, r_last, r_hs, r_load, ar_hs;
  logic [3:0]           r_lat_q;
  logic [DATA_BITS-1:0] rdata_q;

  w_state_e             w_state_q, w_state_d;
  logic [ID_BITS-1:0]   bid_q;
  logic [ADDR_BITS-1:0] w_addr_q;
  logic [7:0]           w_len_q, w_cnt_q;
  logic [2:0]           w_size_q;
  logic [1:0]           w_burst_q, bresp_q, w_resp_beat;
  logic                 w_prot_q, w_oor, w_hs, w_we, aw_hs, wlast_bad;

`ifdef AXI4_RANGE_CHECK_EN
  localparam logic [ADDR_BITS-1:0] MEM_BYTES = ADDR_BITS'(DEPTH * STRB_W);
  assign r_oor = (r_load_addr - BASE_ADDR) >= MEM_BYTES;
  assign w_oor = (w_addr_q - BASE_ADDR) >= MEM_BYTES;
`else
  assign r_oor = 1'b0;
  assign w_oor = 1'b0;
`endif

  // Read channel
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) r_state_q <= R_IDLE;
    else          r_state_q <= r_state_d;
  end

  always_comb begin
    r_state_d = r_state_q;
    arready_o = 1'b0;
    rvalid_o  = 1'b0;
    r_last    = 1'b0;
    unique case (r_state_q)
      R_IDLE: begin
        arready_o = 1'b1;
        if (arvalid_i) r_state_d = R_LAT;
      end
      R_LAT: if (r_lat_q == 4'd0) r_state_d = R_DATA;
      R_DATA: begin
        rvalid_o = 1'b1;
        r_last   = (r_cnt_q == 8'd0);
        if (rready_i && r_last) r_state_d = R_IDLE;
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  assign ar_hs       = arready_o & arvalid_i;
  assign r_hs        = rvalid_o & rready_i;
  assign r_next      = next_addr(r_addr_q, r_len_q, r_size_q, r_burst_q);
  assign r_load_addr = (r_state_q == R_DATA) ? r_next : r_addr_q;
  assign r_load      = ((r_state_q == R_LAT) && (r_lat_q == 4'd0)) || (r_hs && !r_last);
  assign r_resp_d    = r_oor ? 2'b11 : (r_prot_q ? 2'b10 : 2'b00);

  // Memory array read uses pre-edge contents, so a same-cycle write is not visible here
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      rid_q <= '0; r_addr_q <= '0; r_len_q <= '0; r_cnt_q <= '0; r_size_q <= '0;
      r_burst_q <= '0; r_prot_q <= 1'b0; r_lat_q <= '0; rdata_q <= '0; rresp_q <= '0;
    end else begin
      if (ar_hs) begin
        rid_q     <= arid_i;
        r_addr_q  <= araddr_i;
        r_len_q   <= arlen_i;
        r_cnt_q   <= arlen_i;
        r_size_q  <= arsize_i;
        r_burst_q <= arburst_i;
        r_prot_q  <= prot_err(arlen_i, arsize_i, arburst_i);
        r_lat_q   <= 4'(READ_LATENCY);
      end
      if (r_state_q == R_LAT && r_lat_q != 4'd0) r_lat_q <= r_lat_q - 4'd1;
      if (r_load) begin
        r_addr_q <= r_load_addr;
        rresp_q  <= r_resp_d;
        rdata_q  <= (r_resp_d != 2'b00) ? '0 : mem[word_idx(r_load_addr)];
      end
      if (r_hs && !r_last) r_cnt_q <= r_cnt_q - 8'd1;
    end
  end

  assign rid_o   = rid_q;
  assign rdata_o = rdata_q;
  assign rresp_o = rresp_q;
  assign rlast_o = r_last;

  // Write channel
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) w_state_q <= W_IDLE;
    else          w_state_q <= w_state_d;
  end

  always_comb begin
    w_state_d = w_state_q;
    awready_o = 1'b0;
    wready_o  = 1'b0;
    bvalid_o  = 1'b0;
    unique case (w_state_q)
      W_IDLE: begin
        awready_o = 1'b1;
        if (awvalid_i) w_state_d = W_DATA;
      end
      W_DATA: begin
        wready_o = 1'b1;
        if (wvalid_i && w_cnt_q == 8'd0) w_state_d = W_RESP;
      end
      W_RESP: begin
        bvalid_o = 1'b1;
        if (bready_i) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  assign aw_hs       = awready_o & awvalid_i;
  assign w_hs        = wready_o & wvalid_i;
  assign w_resp_beat = w_oor ? 2'b11 : (w_prot_q ? 2'b10 : 2'b00);
  assign w_we        = w_hs && (w_resp_beat == 2'b00);
  // The beat count owns burst termination; wlast only flags a mismatch
  assign wlast_bad   = wlast_i != (w_cnt_q == 8'd0);

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      bid_q <= '0; w_addr_q <= '0; w_len_q <= '0; w_cnt_q <= '0; w_size_q <= '0;
      w_burst_q <= '0; w_prot_q <= 1'b0; bresp_q <= '0;
    end else begin
      if (aw_hs) begin
        bid_q     <= awid_i;
        w_addr_q  <= awaddr_i;
        w_len_q   <= awlen_i;
        w_cnt_q   <= awlen_i;
        w_size_q  <= awsize_i;
        w_burst_q <= awburst_i;
        w_prot_q  <= prot_err(awlen_i, awsize_i, awburst_i);
        bresp_q   <= prot_err(awlen_i, awsize_i, awburst_i) ? 2'b10 : 2'b00;
      end
      if (w_hs) begin
        w_addr_q <= next_addr(w_addr_q, w_len_q, w_size_q, w_burst_q);
        if (w_cnt_q != 8'd0) w_cnt_q <= w_cnt_q - 8'd1;
        bresp_q  <= worst(worst(bresp_q, w_resp_beat), wlast_bad ? 2'b10 : 2'b00);
      end
    end
  end

  always_ff @(posedge PCLK) begin
    if (w_we) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (wstrb_i[b]) mem[word_idx(w_addr_q)][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  assign bid_o   = bid_q;
  assign bresp_o = bresp_q;

endmodule

// File: tb/tb_axi4_sram_slave.sv
// Scenario bench for axi4_sram_slave: read beats are checked against a queue of expected beats.
module tb_axi4_sram_slave;
  localparam int RL = 1;

  logic        PCLK, PRESETn;
  logic [3:0]  arid, awid, rid, bid;
  logic [31:0] araddr, awaddr, rdata, wdata;
  logic [7:0]  arlen, awlen;
  logic [2:0]  arsize, awsize;
  logic [1:0]  arburst, awburst, rresp, bresp;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic [3:0]  wstrb;

  axi4_sram_slave #(.READ_LATENCY(RL)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .arid_i(arid), .araddr_i(araddr), .arlen_i(arlen), .arsize_i(arsize),
    .arburst_i(arburst), .arvalid_i(arvalid), .arready_o(arready),
    .rid_o(rid), .rdata_o(rdata), .rresp_o(rresp), .rlast_o(rlast),
    .rvalid_o(rvalid), .rready_i(rready),
    .awid_i(awid), .awaddr_i(awaddr), .awlen_i(awlen), .awsize_i(awsize),
    .awburst_i(awburst), .awvalid_i(awvalid), .awready_o(awready),
    .wdata_i(wdata), .wstrb_i(wstrb), .wlast_i(wlast), .wvalid_i(wvalid),
    .wready_o(wready),
    .bid_o(bid), .bresp_o(bresp), .bvalid_o(bvalid), .bready_i(bready)
  );

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } rbeat_t;

  rbeat_t      exp_q[$];
  logic [31:0] wq[$];
  logic [3:0]  sq[$];
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          ar_cyc = 0;

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;
  always @(posedge PCLK) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Read-beat scoreboard: a handshake is seen at the negedge before its clock edge
  always @(negedge PCLK) begin
    rbeat_t act, expv;
    if (PRESETn && rvalid && rready) begin
      act = {rid, rdata, rresp, rlast};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rbeat_unexpected got id=%h data=%h resp=%b last=%b", rid, rdata, rresp, rlast);
      end else begin
        expv = exp_q.pop_front();
        if (act !== expv) begin
          errors++;
          $display("FAIL rbeat got id=%h data=%h resp=%b last=%b required id=%h data=%h resp=%b last=%b",
                   act.id, act.data, act.resp, act.last, expv.id, expv.data, expv.resp, expv.last);
        end
      end
    end
  end

  task automatic push_r(input logic [3:0] id, input logic [31:0] d, input logic [1:0] r,
                        input logic l);
    exp_q.push_back({id, d, r, l});
  endtask

  task automatic do_ar(input logic [3:0] id, input logic [31:0] a, input logic [7:0] len,
                       input logic [2:0] size, input logic [1:0] burst);
    int n;
    arid = id; araddr = a; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
    n = 0;
    do begin @(negedge PCLK); n++; end while (!arready && n < 50);
    if (!arready) begin
      errors++; checks++;
      $display("FAIL ar_timeout arready=%b required=1", arready);
    end
    @(posedge PCLK); #1;
    arvalid = 1'b0;
    ar_cyc = cyc;
  endtask

  task automatic wait_rvalid(output int at);
    int n;
    n = 0;
    do begin @(negedge PCLK); n++; end while (!rvalid && n < 50);
    if (!rvalid) begin
      errors++; checks++;
      $display("FAIL rvalid_timeout rvalid=%b required=1", rvalid);
    end
    at = cyc;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 600) begin @(negedge PCLK); n++; end
    if (exp_q.size() > 0) begin
      errors++; checks++;
      $display("FAIL read_drain_timeout pending=%0d required=0", exp_q.size());
      exp_q.delete();
    end
    @(posedge PCLK); #1;
  endtask

  task automatic do_write(input logic [3:0] id, input logic [31:0] a, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst, input int bad_last,
                          output logic [1:0] r, output logic [3:0] b, output int bdelay);
    int n;
    awid = id; awaddr = a; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
    n = 0;
    do begin @(negedge PCLK); n++; end while (!awready && n < 50);
    if (!awready) begin
      errors++; checks++;
      $display("FAIL aw_timeout awready=%b required=1", awready);
    end
    @(posedge PCLK); #1;
    awvalid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      wvalid = 1'b1;
      wdata  = wq.pop_front();
      wstrb  = sq.pop_front();
      wlast  = (i == int'(len)) ^ (i == bad_last);
      n = 0;
      do begin @(negedge PCLK); n++; end while (!wready && n < 50);
      if (!wready) begin
        errors++; checks++;
        $display("FAIL w_timeout wready=%b required=1", wready);
      end
      @(posedge PCLK); #1;
    end
    wvalid = 1'b0; wlast = 1'b0; bready = 1'b1;
    bdelay = 0;
    @(negedge PCLK);
    while (!bvalid && bdelay < 50) begin bdelay++; @(negedge PCLK); end
    if (!bvalid) begin
      errors++; checks++;
      $display("FAIL b_timeout bvalid=%b required=1", bvalid);
    end
    r = bresp; b = bid;
    @(posedge PCLK); #1;
    bready = 1'b0;
  endtask

  task automatic test_reset();
    PRESETn = 1'b0;
    arvalid = 0; awvalid = 0; wvalid = 0; wlast = 0; rready = 0; bready = 0;
    arid = 0; araddr = 0; arlen = 0; arsize = 0; arburst = 0;
    awid = 0; awaddr = 0; awlen = 0; awsize = 0; awburst = 0; wdata = 0; wstrb = 0;
    repeat (3) @(negedge PCLK);
    checks++; if (arready !== 1'b1) begin errors++; $display("FAIL reset_arready got=%b required=1", arready); end
    checks++; if (awready !== 1'b1) begin errors++; $display("FAIL reset_awready got=%b required=1", awready); end
    checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid got=%b required=0", rvalid); end
    checks++; if (wready !== 1'b0) begin errors++; $display("FAIL reset_wready got=%b required=0", wready); end
    checks++; if (bvalid !== 1'b0) begin errors++; $display("FAIL reset_bvalid got=%b required=0", bvalid); end
    checks++; if (rlast !== 1'b0) begin errors++; $display("FAIL reset_rlast got=%b required=0", rlast); end
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got=%h required=0", rdata); end
    checks++; if (rresp !== 2'b00) begin errors++; $display("FAIL reset_rresp got=%b required=00", rresp); end
    checks++; if (rid !== 4'h0) begin errors++; $display("FAIL reset_rid got=%h required=0", rid); end
    checks++; if (bresp !== 2'b00) begin errors++; $display("FAIL reset_bresp got=%b required=00", bresp); end
    checks++; if (bid !== 4'h0) begin errors++; $display("FAIL reset_bid got=%h required=0", bid); end
    @(posedge PCLK); #1;
    PRESETn = 1'b1;
    @(posedge PCLK); #1;
  endtask

  task automatic test_incr();
    logic [1:0] r; logic [3:0] b; int bd, fc;
    wq = '{32'h11, 32'h22, 32'h33, 32'h44};
    sq = '{4'hF, 4'hF, 4'hF, 4'hF};
    do_write(4'h3, 32'h1000_0000, 8'd3, 3'd2, 2'b01, -1, r, b, bd);
    checks++; if (r !== 2'b00) begin errors++; $display("FAIL incr_bresp got=%b required=00", r); end
    checks++; if (b !== 4'h3) begin errors++; $display("FAIL incr_bid got=%h required=3", b); end
    checks++; if (bd !== 0) begin errors++; $display("FAIL incr_bvalid_delay got=%0d required=0", bd); end
    rready = 1'b1;
    push_r(4'h5, 32'h11, 2'b00, 1'b0);
    push_r(4'h5, 32'h22, 2'b00, 1'b0);
    push_r(4'h5, 32'h33, 2'b00, 1'b0);
    push_r(4'h5, 32'h44, 2'b00, 1'b1);
    do_ar(4'h5, 32'h1000_0000, 8'd3, 3'd2, 2'b01);
    wait_rvalid(fc);
    checks++;
    if (fc !== ar_cyc + 1 + RL) begin
      errors++; $display("FAIL incr_first_rvalid_cycle got=%0d required=%0d", fc - ar_cyc, 1 + RL);
    end
    wait_drain();
  endtask

  task automatic test_wrap();
    push_r(4'h6, 32'h33, 2'b00, 1'b0);
    push_r(4'h6, 32'h44, 2'b00, 1'b0);
    push_r(4'h6, 32'h11, 2'b00, 1'b0);
    push_r(4'h6, 32'h22, 2'b00, 1'b1);
    do_ar(4'h6, 32'h1000_0008, 8'd3, 3'd2, 2'b10);
    wait_drain();
  endtask

  task automatic test_strobe();
    logic [1:0] r; logic [3:0] b; int bd;
    wq = '{32'h0}; sq = '{4'hF};
    do_write(4'h1, 32'h1000_0040, 8'd0, 3'd2, 2'b01, -1, r, b, bd);
    wq = '{32'hAABB_CCDD}; sq = '{4'b0101};
    do_write(4'h2, 32'h1000_0040, 8'd0, 3'd2, 2'b01, -1, r, b, bd);
    checks++; if (r !== 2'b00) begin errors++; $display("FAIL strobe_bresp got=%b required=00", r); end
    push_r(4'h1, 32'h00BB_00DD, 2'b00, 1'b1);
    do_ar(4'h1, 32'h1000_0040, 8'd0, 3'd2, 2'b01);
    wait_drain();
  endtask

  task automatic test_range();
`ifdef AXI4_RANGE_CHECK_EN
    push_r(4'h9, 32'h0, 2'b11, 1'b1);
`else
    push_r(4'h9, 32'h11, 2'b00, 1'b1);
`endif
    do_ar(4'h9, 32'h2000_0000, 8'd0, 3'd2, 2'b01);
    wait_drain();
  endtask

  task automatic test_wlast();
    logic [1:0] r; logic [3:0] b; int bd;
    wq = '{32'hA1, 32'hB2}; sq = '{4'hF, 4'hF};
    do_write(4'hC, 32'h1000_0080, 8'd1, 3'd2, 2'b01, 0, r, b, bd);
    checks++; if (r !== 2'b10) begin errors++; $display("FAIL wlast_bresp got=%b required=10", r); end
    checks++; if (b !== 4'hC) begin errors++; $display("FAIL wlast_bid got=%h required=c", b); end
    push_r(4'h2, 32'hA1, 2'b00, 1'b0);
    push_r(4'h2, 32'hB2, 2'b00, 1'b1);
    do_ar(4'h2, 32'h1000_0080, 8'd1, 3'd2, 2'b01);
    wait_drain();
  endtask

  task automatic test_protocol_err();
    logic [1:0] r; logic [3:0] b; int bd;
    push_r(4'h2, 32'h0, 2'b10, 1'b0);
    push_r(4'h2, 32'h0, 2'b10, 1'b0);
    push_r(4'h2, 32'h0, 2'b10, 1'b1);
    do_ar(4'h2, 32'h1000_0000, 8'd2, 3'd2, 2'b10);
    wait_drain();
    wq = '{32'hFFFF_FFFF}; sq = '{4'hF};
    do_write(4'h4, 32'h1000_0040, 8'd0, 3'd3, 2'b01, -1, r, b, bd);
    checks++; if (r !== 2'b10) begin errors++; $display("FAIL size_err_bresp got=%b required=10", r); end
    push_r(4'h3, 32'h00BB_00DD, 2'b00, 1'b1);
    do_ar(4'h3, 32'h1000_0040, 8'd0, 3'd2, 2'b01);
    wait_drain();
  endtask

  task automatic test_stall_concurrent();
    logic [1:0] r; logic [3:0] b; int bd, fc;
    logic [38:0] stall_exp;
    stall_exp = {4'h7, 32'h22, 2'b00, 1'b0};
    wq = '{32'h55, 32'h66}; sq = '{4'hF, 4'hF};
    rready = 1'b1;
    push_r(4'h7, 32'h11, 2'b00, 1'b0);
    push_r(4'h7, 32'h22, 2'b00, 1'b0);
    push_r(4'h7, 32'h33, 2'b00, 1'b0);
    push_r(4'h7, 32'h44, 2'b00, 1'b1);
    fork
      begin
        do_ar(4'h7, 32'h1000_0000, 8'd3, 3'd2, 2'b01);
        wait_rvalid(fc);
        @(posedge PCLK); #1;
        rready = 1'b0;
        for (int k = 0; k < 5; k++) begin
          @(negedge PCLK);
          checks++;
          if (!rvalid || {rid, rdata, rresp, rlast} !== stall_exp) begin
            errors++;
            $display("FAIL stall_hold cycle=%0d got v=%b id=%h data=%h resp=%b last=%b required v=1 id=7 data=22 resp=00 last=0",
                     k, rvalid, rid, rdata, rresp, rlast);
          end
        end
        @(posedge PCLK); #1;
        rready = 1'b1;
        wait_drain();
      end
      begin
        do_write(4'hA, 32'h1000_0100, 8'd1, 3'd2, 2'b01, -1, r, b, bd);
      end
    join
    checks++; if (r !== 2'b00) begin errors++; $display("FAIL concurrent_bresp got=%b required=00", r); end
    checks++; if (b !== 4'hA) begin errors++; $display("FAIL concurrent_bid got=%h required=a", b); end
    push_r(4'h8, 32'h55, 2'b00, 1'b0);
    push_r(4'h8, 32'h66, 2'b00, 1'b1);
    do_ar(4'h8, 32'h1000_0100, 8'd1, 3'd2, 2'b01);
    wait_drain();
  endtask

  task automatic test_reset_midburst();
    int fc, n;
    rready = 1'b0;
    do_ar(4'hB, 32'h1000_0000, 8'd7, 3'd2, 2'b01);
    wait_rvalid(fc);
    @(posedge PCLK); #2;
    PRESETn = 1'b0;
    #1;
    checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL rst_mid_rvalid got=%b required=0", rvalid); end
    checks++; if (arready !== 1'b1) begin errors++; $display("FAIL rst_mid_arready got=%b required=1", arready); end
    checks++; if (rlast !== 1'b0) begin errors++; $display("FAIL rst_mid_rlast got=%b required=0", rlast); end
    @(posedge PCLK); #1;
    PRESETn = 1'b1;
    @(posedge PCLK); #1;
    // write one beat of a four-beat burst, then reset
    awid = 4'hD; awaddr = 32'h1000_0200; awlen = 8'd3; awsize = 3'd2; awburst = 2'b01;
    awvalid = 1'b1;
    @(negedge PCLK);
    @(posedge PCLK); #1;
    awvalid = 1'b0;
    wvalid = 1'b1; wdata = 32'hDEAD_BEEF; wstrb = 4'hF; wlast = 1'b0;
    n = 0;
    do begin @(negedge PCLK); n++; end while (!wready && n < 50);
    @(posedge PCLK); #1;
    wdata = 32'h1234_5678;
    #1;
    PRESETn = 1'b0;
    #1;
    wvalid = 1'b0;
    checks++; if (wready !== 1'b0) begin errors++; $display("FAIL rst_mid_wready got=%b required=0", wready); end
    checks++; if (awready !== 1'b1) begin errors++; $display("FAIL rst_mid_awready got=%b required=1", awready); end
    @(posedge PCLK); #1;
    PRESETn = 1'b1;
    bready = 1'b1;
    n = 0;
    for (int k = 0; k < 4; k++) begin @(negedge PCLK); if (bvalid) n++; end
    bready = 1'b0;
    checks++; if (n !== 0) begin errors++; $display("FAIL rst_mid_no_bresp got=%0d cycles with bvalid required=0", n); end
    rready = 1'b1;
    push_r(4'hE, 32'hDEAD_BEEF, 2'b00, 1'b1);
    do_ar(4'hE, 32'h1000_0200, 8'd0, 3'd2, 2'b01);
    wait_drain();
  endtask

  initial begin
    test_reset();
    test_incr();
    test_wrap();
    test_strobe();
    test_range();
    test_wlast();
    test_protocol_err();
    test_stall_concurrent();
    test_reset_midburst();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
